// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with any depth >= 2, exact occupancy count,
// programmable almost-full/almost-empty, optional first-word-fall-through and sticky errors.
module param_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 333,
    parameter int AF_THRESH  = 330,
    parameter int AE_THRESH  = 3,
    parameter int FWFT       = 0,
    localparam int PTR_WIDTH = $clog2(MEM_DEPTH),
    localparam int CNT_WIDTH = $clog2(MEM_DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  W_EN,
    input  logic [DATA_WIDTH-1:0] I_DATA,
    input  logic                  R_EN,
    input  logic                  CLR_ERR,
    output logic [DATA_WIDTH-1:0] O_DATA,
    output logic                  O_VALID,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [CNT_WIDTH-1:0]  COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam logic [PTR_WIDTH-1:0] LAST_ADDR = PTR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL  = CNT_WIDTH'(MEM_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_AF    = CNT_WIDTH'(AF_THRESH);
    localparam logic [CNT_WIDTH-1:0] CNT_AE    = CNT_WIDTH'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [PTR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [PTR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 full, empty, wr_ok, rd_ok;

    // Flags come only from the registered count, never from this cycle's requests.
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign wr_ok = W_EN && !full;
    assign rd_ok = R_EN && !empty;

    assign FULL         = full;
    assign EMPTY        = empty;
    assign ALMOST_FULL  = (count_q >= CNT_AF);
    assign ALMOST_EMPTY = (count_q <= CNT_AE);
    assign COUNT        = count_q;
    assign OVERFLOW     = overflow_q;
    assign UNDERFLOW    = underflow_q;

    always_comb begin
        w_addr_d    = w_addr_q;
        r_addr_d    = r_addr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        // Depth need not be a power of two, so wrap explicitly at the last word.
        if (wr_ok) w_addr_d = (w_addr_q == LAST_ADDR) ? '0 : w_addr_q + PTR_ONE;
        if (rd_ok) r_addr_d = (r_addr_q == LAST_ADDR) ? '0 : r_addr_q + PTR_ONE;

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A new error in the same cycle as a clear must stay visible.
        if (CLR_ERR)        overflow_d  = 1'b0;
        if (W_EN && full)   overflow_d  = 1'b1;
        if (CLR_ERR)        underflow_d = 1'b0;
        if (R_EN && empty)  underflow_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            w_addr_q    <= '0;
            r_addr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_addr_q    <= w_addr_d;
            r_addr_q    <= r_addr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_ok) mem[w_addr_q] <= I_DATA;
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
            logic                  o_valid_q, o_valid_d;

            always_comb begin
                o_data_d  = o_data_q;
                o_valid_d = rd_ok;
                if (rd_ok) o_data_d = mem[r_addr_q];
            end

            always_ff @(posedge CLK or negedge RST_n) begin
                if (!RST_n) begin
                    o_data_q  <= '0;
                    o_valid_q <= 1'b0;
                end else begin
                    o_data_q  <= o_data_d;
                    o_valid_q <= o_valid_d;
                end
            end

            assign O_DATA  = o_data_q;
            assign O_VALID = o_valid_q;
        end else begin : g_fwft
            // Head word is shown directly; forced to zero while empty so reset reads 0.
            assign O_DATA  = empty ? '0 : mem[r_addr_q];
            assign O_VALID = !empty;
        end
    endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Testbench for param_sync_fifo: a standard-mode FIFO (depth 333) and a FWFT FIFO (depth 5)
// share one stimulus stream and are compared against queue-based reference models.
module tb_param_sync_fifo;

    localparam int D0 = 333, AF0 = 330, AE0 = 3;
    localparam int D1 = 5,   AF1 = 4,   AE1 = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       w_en = 1'b0, r_en = 1'b0, clr_err = 1'b0;
    logic [7:0] i_data = 8'h00;

    logic [7:0] o_data0, o_data1;
    logic       o_valid0, full0, empty0, af0, ae0, ovf0, unf0;
    logic       o_valid1, full1, empty1, af1, ae1, ovf1, unf1;
    logic [8:0] count0;
    logic [2:0] count1;

    always #5 clk = ~clk;

    param_sync_fifo #(.DATA_WIDTH(8), .MEM_DEPTH(D0), .AF_THRESH(AF0), .AE_THRESH(AE0), .FWFT(0)) dut0 (
        .CLK(clk), .RST_n(rst_n), .W_EN(w_en), .I_DATA(i_data), .R_EN(r_en), .CLR_ERR(clr_err),
        .O_DATA(o_data0), .O_VALID(o_valid0), .FULL(full0), .EMPTY(empty0),
        .ALMOST_FULL(af0), .ALMOST_EMPTY(ae0), .COUNT(count0), .OVERFLOW(ovf0), .UNDERFLOW(unf0)
    );

    param_sync_fifo #(.DATA_WIDTH(8), .MEM_DEPTH(D1), .AF_THRESH(AF1), .AE_THRESH(AE1), .FWFT(1)) dut1 (
        .CLK(clk), .RST_n(rst_n), .W_EN(w_en), .I_DATA(i_data), .R_EN(r_en), .CLR_ERR(clr_err),
        .O_DATA(o_data1), .O_VALID(o_valid1), .FULL(full1), .EMPTY(empty1),
        .ALMOST_FULL(af1), .ALMOST_EMPTY(ae1), .COUNT(count1), .OVERFLOW(ovf1), .UNDERFLOW(unf1)
    );

    // Reference model state: contents as queues, plus registered read output and sticky errors.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] m_odata0;
    bit         m_ovalid0;
    bit         m_ovf[2];
    bit         m_unf[2];

    int    n_checks = 0;
    int    n_fail = 0;
    string phase = "init";

    typedef struct {
        bit         w;
        bit         r;
        bit         clr;
        logic [7:0] d;
        int         cnt;
        bit         valid;
        logic [7:0] data;
        bit         ovf;
        bit         unf;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s/%s: got 0x%0h, expected 0x%0h at %0t", phase, name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        q0.delete();
        q1.delete();
        m_odata0  = 8'h00;
        m_ovalid0 = 1'b0;
        m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
        m_unf[0] = 1'b0; m_unf[1] = 1'b0;
    endtask

    // One clock edge of FIFO behaviour computed from the pre-edge occupancy.
    task automatic modelStep(input bit w, input bit r, input bit clr, input logic [7:0] d);
        for (int k = 0; k < 2; k++) begin
            int sz;
            int dep;
            bit f, e, wa, ra;
            sz  = (k == 0) ? q0.size() : q1.size();
            dep = (k == 0) ? D0 : D1;
            f   = (sz == dep);
            e   = (sz == 0);
            wa  = w && !f;
            ra  = r && !e;
            if (w && f)   m_ovf[k] = 1'b1;
            else if (clr) m_ovf[k] = 1'b0;
            if (r && e)   m_unf[k] = 1'b1;
            else if (clr) m_unf[k] = 1'b0;
            if (k == 0) begin
                if (ra) begin
                    m_odata0  = q0.pop_front();
                    m_ovalid0 = 1'b1;
                end else begin
                    m_ovalid0 = 1'b0;
                end
                if (wa) q0.push_back(d);
            end else begin
                if (ra) void'(q1.pop_front());
                if (wa) q1.push_back(d);
            end
        end
    endtask

    task automatic checkOutput();
        check("count0", count0, q0.size());
        check("full0", full0, q0.size() == D0);
        check("empty0", empty0, q0.size() == 0);
        check("afull0", af0, q0.size() >= AF0);
        check("aempty0", ae0, q0.size() <= AE0);
        check("valid0", o_valid0, m_ovalid0);
        check("data0", o_data0, m_odata0);
        check("ovf0", ovf0, m_ovf[0]);
        check("unf0", unf0, m_unf[0]);
        check("count1", count1, q1.size());
        check("full1", full1, q1.size() == D1);
        check("empty1", empty1, q1.size() == 0);
        check("afull1", af1, q1.size() >= AF1);
        check("aempty1", ae1, q1.size() <= AE1);
        check("valid1", o_valid1, q1.size() != 0);
        if (q1.size() != 0) check("data1", o_data1, q1[0]);
        check("ovf1", ovf1, m_ovf[1]);
        check("unf1", unf1, m_unf[1]);
    endtask

    task automatic applyStimulus(input bit w, input bit r, input bit clr, input logic [7:0] d);
        @(negedge clk);
        w_en = w; r_en = r; clr_err = clr; i_data = d;
        modelStep(w, r, clr, d);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        @(negedge clk);
        w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; i_data = 8'h00;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1, 0, 0, 8'h01, 1, 0, 8'h00, 0, 0};
        tbl[1]  = '{1, 0, 0, 8'h02, 2, 0, 8'h00, 0, 0};
        tbl[2]  = '{1, 0, 0, 8'h03, 3, 0, 8'h00, 0, 0};
        tbl[3]  = '{1, 0, 0, 8'h04, 4, 0, 8'h00, 0, 0};
        tbl[4]  = '{1, 0, 0, 8'h05, 5, 0, 8'h00, 0, 0};
        tbl[5]  = '{0, 1, 0, 8'h00, 4, 1, 8'h01, 0, 0};
        tbl[6]  = '{0, 1, 0, 8'h00, 3, 1, 8'h02, 0, 0};
        tbl[7]  = '{0, 1, 0, 8'h00, 2, 1, 8'h03, 0, 0};
        tbl[8]  = '{0, 1, 0, 8'h00, 1, 1, 8'h04, 0, 0};
        tbl[9]  = '{0, 1, 0, 8'h00, 0, 1, 8'h05, 0, 0};
        tbl[10] = '{0, 0, 0, 8'h00, 0, 0, 8'h05, 0, 0};
        tbl[11] = '{0, 1, 0, 8'h00, 0, 0, 8'h05, 0, 1};
        tbl[12] = '{0, 0, 1, 8'h00, 0, 0, 8'h05, 0, 0};

        phase = "reset";
        #1;
        modelReset();
        checkOutput();
        check("rst_count", count0, 0);
        check("rst_aempty", ae0, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write-then-read ordering with one-cycle read latency.
        phase = "table";
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].w, tbl[i].r, tbl[i].clr, tbl[i].d);
            check("tbl_count", count0, tbl[i].cnt);
            check("tbl_valid", o_valid0, tbl[i].valid);
            check("tbl_data", o_data0, tbl[i].data);
            check("tbl_ovf", ovf0, tbl[i].ovf);
            check("tbl_unf", unf0, tbl[i].unf);
        end
        check("tbl_empty", empty0, 1);

        phase = "fill";
        doReset();
        for (int i = 0; i < D0; i++) begin
            applyStimulus(1, 0, 0, 8'(i));
            if (i == AF0 - 2) check("af_below", af0, 0);
            if (i == AF0 - 1) check("af_at", af0, 1);
            if (i == D0 - 2)  check("full_below", full0, 0);
        end
        check("full_at", full0, 1);
        check("full_count", count0, D0);
        applyStimulus(1, 0, 0, 8'hEE);
        check("ovf_set", ovf0, 1);
        check("ovf_count", count0, D0);
        applyStimulus(0, 0, 1, 8'h00);
        check("ovf_clr", ovf0, 0);

        phase = "both_full";
        applyStimulus(1, 1, 0, 8'hEE);
        check("bf_count", count0, D0 - 1);
        check("bf_ovf", ovf0, 1);
        for (int i = 0; i < D0 - 1; i++) applyStimulus(0, 1, 0, 8'h00);
        check("drain_empty", empty0, 1);

        phase = "both_empty";
        applyStimulus(1, 1, 0, 8'h3C);
        check("be_count", count0, 1);
        check("be_unf", unf0, 1);
        check("be_valid", o_valid0, 0);
        applyStimulus(0, 1, 1, 8'h00);
        check("be_data", o_data0, 8'h3C);

        phase = "wrap";
        doReset();
        for (int i = 0; i < 300; i++) applyStimulus(1, 0, 0, 8'(i * 7 + 1));
        for (int i = 0; i < 300; i++) applyStimulus(0, 1, 0, 8'h00);
        for (int i = 0; i < 100; i++) applyStimulus(1, 0, 0, 8'(i * 3 + 5));
        for (int i = 0; i < 100; i++) applyStimulus(0, 1, 0, 8'h00);
        check("wrap_count", count0, 0);

        phase = "fwft";
        doReset();
        applyStimulus(1, 0, 0, 8'hA5);
        check("fwft_valid", o_valid1, 1);
        check("fwft_data", o_data1, 8'hA5);
        applyStimulus(0, 0, 0, 8'h00);
        check("fwft_hold", o_data1, 8'hA5);
        applyStimulus(0, 1, 0, 8'h00);
        check("fwft_empty", empty1, 1);
        check("fwft_novalid", o_valid1, 0);

        // Asynchronous reset in the middle of a burst.
        phase = "midreset";
        doReset();
        for (int i = 0; i < 50; i++) applyStimulus(1, 0, 0, 8'(i + 1));
        check("mid_count50", count0, 50);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        check("mid_count0", count0, 0);
        check("mid_empty", empty0, 1);
        @(negedge clk);
        w_en = 1'b0; r_en = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 8'(8'h80 + i));
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 0, 8'h00);
            check("mid_newdata", o_data0, 8'(8'h80 + i));
        end

        phase = "random";
        doReset();
        for (int i = 0; i < 2000; i++) begin
            int wp;
            wp = ((i / 500) % 2 == 0) ? 80 : 25;
            applyStimulus($urandom_range(0, 99) < wp, $urandom_range(0, 99) < 50,
                          $urandom_range(0, 99) < 5, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
